// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with branch decode and a
// circular return-address stack for call/return, with stall support
// and sticky stack overflow/underflow flags.
module pc_sequencer #(
    parameter int                 WIDTH     = 32,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0]   RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [1:0]                   BS,
    input  logic                         PS,
    input  logic                         Z,
    input  logic [WIDTH-1:0]             BrA,
    input  logic [WIDTH-1:0]             RAA,
    input  logic                         link,
    input  logic                         ret,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_plus1,
    output logic [WIDTH-1:0]             next_pc,
    output logic                         taken,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // Stack storage; top_ptr indexes the most recently pushed entry.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] ras_top;

    logic cond_true;
    logic jump_sel;
    logic ras_empty;
    logic ras_full;
    logic do_pop;
    logic do_push;
    logic unf_event;

    assign pc_plus1  = pc + PC_ONE;
    assign wr_ptr    = top_ptr + PTR_ONE;
    assign ras_top   = ras_mem[top_ptr];
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_FULL);

    // Decode the branch fields and decide whether the stack is touched.
    always_comb begin
        cond_true = (Z == PS);
        jump_sel  = 1'b0;
        case (BS)
            2'b01:   jump_sel = cond_true;
            2'b10:   jump_sel = 1'b1;
            2'b11:   jump_sel = 1'b1;
            default: jump_sel = 1'b0;
        endcase
        do_pop    = ret && !ras_empty;
        unf_event = ret && ras_empty;
        do_push   = link && !ret && jump_sel;
    end

    // Select the next PC: a return overrides everything, then the branch field.
    always_comb begin
        next_pc = pc_plus1;
        taken   = 1'b0;
        if (ret) begin
            if (!ras_empty) begin
                next_pc = ras_top;
                taken   = 1'b1;
            end
        end else begin
            case (BS)
                2'b11: begin
                    next_pc = BrA;
                    taken   = 1'b1;
                end
                2'b10: begin
                    next_pc = RAA;
                    taken   = 1'b1;
                end
                2'b01: begin
                    if (cond_true) begin
                        next_pc = BrA;
                        taken   = 1'b1;
                    end
                end
                default: begin
                    next_pc = pc_plus1;
                    taken   = 1'b0;
                end
            endcase
        end
    end

    // Commit PC, stack pointer, count and sticky flags once per unstalled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            top_ptr   <= '1;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (do_pop) begin
                top_ptr   <= top_ptr - PTR_ONE;
                ras_count <= ras_count - CNT_ONE;
            end else if (do_push) begin
                top_ptr <= wr_ptr;
                if (ras_full) begin
                    ras_ovf <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_ONE;
                end
            end
            if (unf_event) begin
                ras_unf <= 1'b1;
            end
        end
    end

    // Write the return address into the slot above the current top; a full
    // stack wraps onto and replaces its oldest entry.
    always_ff @(posedge clk) begin
        if (rst_n && !stall && do_push) begin
            ras_mem[wr_ptr] <= pc_plus1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. A queue-based
// reference model predicts each committed state; combinational outputs
// are checked before the edge, registered outputs after it.
module tb_pc_sequencer;

    localparam int          WIDTH     = 32;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RST_PC    = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  BS;
    logic        PS;
    logic        Z;
    logic [31:0] BrA;
    logic [31:0] RAA;
    logic        link;
    logic        ret;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] next_pc;
    logic        taken;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_stack[$];
    logic [31:0] m_pc;
    logic        m_ovf;
    logic        m_unf;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(
        .WIDTH(WIDTH),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .BS(BS),
        .PS(PS),
        .Z(Z),
        .BrA(BrA),
        .RAA(RAA),
        .link(link),
        .ret(ret),
        .pc(pc),
        .pc_plus1(pc_plus1),
        .next_pc(next_pc),
        .taken(taken),
        .ras_count(ras_count),
        .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hold reset for one edge with the given ret/link, then check the reset state.
    task automatic applyReset(input logic rt, input logic lnk);
        rst_n = 1'b0;
        stall = 1'b0;
        BS    = 2'b11;
        BrA   = 32'h0000_0055;
        ret   = rt;
        link  = lnk;
        @(posedge clk);
        #1;
        m_pc  = RST_PC;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_plus1", pc_plus1, RST_PC + 32'd1);
        checkOutput("rst_cnt", 32'(ras_count), 32'd0);
        checkOutput("rst_ovf", 32'(ras_ovf), 32'd0);
        checkOutput("rst_unf", 32'(ras_unf), 32'd0);
        rst_n = 1'b1;
        ret   = 1'b0;
        link  = 1'b0;
        BS    = 2'b00;
    endtask

    // Drive one cycle, check combinational outputs against the model, queue
    // the predicted committed state, then compare it after the edge.
    task automatic applyStimulus(input string tag, input logic st, input logic [1:0] bs,
                                 input logic ps, input logic z, input logic [31:0] bra,
                                 input logic [31:0] raa, input logic lnk, input logic rt);
        logic [31:0] m_plus1;
        logic [31:0] e_next;
        logic        e_taken;
        exp_t        e;
        exp_t        got;

        stall = st;
        BS    = bs;
        PS    = ps;
        Z     = z;
        BrA   = bra;
        RAA   = raa;
        link  = lnk;
        ret   = rt;

        m_plus1 = m_pc + 32'd1;
        e_next  = m_plus1;
        e_taken = 1'b0;
        if (rt) begin
            if (m_stack.size() > 0) begin
                e_next  = m_stack[$];
                e_taken = 1'b1;
            end
        end else if (bs == 2'b11 || (bs == 2'b01 && z == ps)) begin
            e_next  = bra;
            e_taken = 1'b1;
        end else if (bs == 2'b10) begin
            e_next  = raa;
            e_taken = 1'b1;
        end

        #1;
        checkOutput({tag, "_plus1"}, pc_plus1, m_plus1);
        checkOutput({tag, "_next"}, next_pc, e_next);
        checkOutput({tag, "_taken"}, 32'(taken), 32'(e_taken));

        if (!st) begin
            if (rt) begin
                if (m_stack.size() > 0) begin
                    void'(m_stack.pop_back());
                end else begin
                    m_unf = 1'b1;
                end
            end else if (lnk && e_taken) begin
                if (m_stack.size() == RAS_DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
                m_stack.push_back(m_plus1);
            end
            m_pc = e_next;
        end
        e.tag = tag;
        e.pc  = m_pc;
        e.cnt = m_stack.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            checkOutput({got.tag, "_pc"}, pc, got.pc);
            checkOutput({got.tag, "_cnt"}, 32'(ras_count), 32'(got.cnt));
            checkOutput({got.tag, "_ovf"}, 32'(ras_ovf), 32'(got.ovf));
            checkOutput({got.tag, "_unf"}, 32'(ras_unf), 32'(got.unf));
        end
    endtask

    // Test sequence.
    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        BS    = 2'b00;
        PS    = 1'b0;
        Z     = 1'b0;
        BrA   = '0;
        RAA   = '0;
        link  = 1'b0;
        ret   = 1'b0;
        m_pc  = RST_PC;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        applyReset(1'b0, 1'b0);

        // Straight-line increment from the reset vector.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("inc", 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("inc_104", pc, 32'h0000_0104);

        // Stalled return on an empty stack must not raise underflow.
        applyStimulus("stall_ret", 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Branch decode sweep from a fixed PC; stall keeps pc at 0xCCCCCCCC.
        applyStimulus("jmpC", 1'b0, 2'b11, 1'b0, 1'b0, 32'hCCCC_CCCC, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] sel;
            sel = 4'(i);
            applyStimulus($sformatf("sweep%0d", i), 1'b1, sel[1:0], sel[2], sel[3],
                          32'hBBBB_BBBB, 32'hAAAA_AAAA, 1'b0, 1'b0);
        end

        // Simple call followed immediately by return.
        applyStimulus("to10", 1'b0, 2'b11, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        applyStimulus("call", 1'b0, 2'b11, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0);
        checkOutput("call_pc", pc, 32'h40);
        checkOutput("call_cnt", 32'(ras_count), 32'd1);
        applyStimulus("ret", 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("ret_pc", pc, 32'h11);

        // Five nested calls overflow a four-deep stack, then unwind past empty.
        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("nest%0d", k), 1'b0, 2'b11, 1'b0, 1'b0,
                          32'h1000 * (k + 1), 32'h0, 1'b1, 1'b0);
        end
        checkOutput("nest_cnt", 32'(ras_count), 32'd4);
        checkOutput("nest_ovf", 32'(ras_ovf), 32'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("unwind%0d", k), 1'b0, 2'b00, 1'b0, 1'b0,
                          32'h0, 32'h0, 1'b0, 1'b1);
            if (k == 0) checkOutput("unwind_first", pc, 32'h4001);
        end
        checkOutput("unwind_unf", 32'(ras_unf), 32'd1);
        checkOutput("unwind_pc", pc, 32'h1002);

        // Stalled call holds everything; release performs one jump and one push.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall_call", 1'b1, 2'b11, 1'b0, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0);
        end
        applyStimulus("release", 1'b0, 2'b11, 1'b0, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0);
        checkOutput("release_pc", pc, 32'h700);

        // Reset with ret and link active clears the stack and flags.
        applyReset(1'b1, 1'b1);

        // Conditional and register calls; untaken link does nothing.
        applyStimulus("bcnd_untaken", 1'b0, 2'b01, 1'b0, 1'b1, 32'h300, 32'h0, 1'b1, 1'b0);
        applyStimulus("bcnd_taken", 1'b0, 2'b01, 1'b1, 1'b1, 32'h300, 32'h0, 1'b1, 1'b0);
        applyStimulus("raa_call", 1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h500, 1'b1, 1'b0);
        applyStimulus("inc_link", 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("cond_cnt", 32'(ras_count), 32'd2);

        // Wrap from all ones.
        applyStimulus("toFF", 1'b0, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        applyStimulus("wrap", 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrap_pc", pc, 32'h0);

        // Return beats a simultaneous call.
        applyStimulus("prio_call", 1'b0, 2'b11, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0);
        applyStimulus("prio_ret", 1'b0, 2'b11, 1'b0, 1'b0, 32'h90, 32'h0, 1'b1, 1'b1);
        checkOutput("prio_pc", pc, 32'h1);
        checkOutput("prio_cnt", 32'(ras_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
